// File: rtl/pci_pkg.sv
// Shared constants for the lane demux: default widths and the lane-index encoding.
package pci_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    function automatic lane_e otherLane(input lane_e lane);
        return (lane == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/demux_stripe_l2_if.sv
// Upstream byte stream plus the two downstream lane streams of demux_stripe_l2.
interface demux_stripe_l2_if
    import pci_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic [DATA_W-1:0] dataIn;
    logic              validIn;
    logic              readyOut;
    logic              selector;
    logic              stripeEn;
    logic              laneNext;
    logic [DATA_W-1:0] dataOut0;
    logic [DATA_W-1:0] dataOut1;
    logic              validOut0;
    logic              validOut1;
    logic              readyIn0;
    logic              readyIn1;

    // The block itself: consumes the upstream byte, produces both lane heads.
    modport slave (
        input  dataIn, validIn, selector, stripeEn, readyIn0, readyIn1,
        output readyOut, laneNext, dataOut0, dataOut1, validOut0, validOut1
    );

    // The environment: drives upstream bytes and downstream consumer readiness.
    modport master (
        output dataIn, validIn, selector, stripeEn, readyIn0, readyIn1,
        input  readyOut, laneNext, dataOut0, dataOut1, validOut0, validOut1
    );

endinterface

// File: rtl/demux_stripe_l2_lane_fifo.sv
// First-word-fall-through FIFO for one lane; head entry is visible whenever not empty.
module lane_fifo
    import pci_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              doPush;
    logic              doPop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign headData = mem[rdPtr];
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;

    // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/demux_stripe_l2.sv
// Two-lane byte demux: stripes alternately across lanes or follows the selector.
module demux_stripe_l2
    import pci_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input logic               clk,
    input logic               reset,
    demux_stripe_l2_if.slave  bus
);

    lane_e lanePtr;
    lane_e target;
    logic  full0;
    logic  full1;
    logic  empty0;
    logic  empty1;
    logic  accept;
    logic  push0;
    logic  push1;
    logic  pop0;
    logic  pop1;

    assign target       = bus.stripeEn ? lanePtr : lane_e'(bus.selector);
    assign bus.laneNext = target;
    assign bus.readyOut = (target == LANE1) ? !full1 : !full0;
    assign accept       = bus.validIn && bus.readyOut;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        push0 = 1'b0;
        push1 = 1'b0;
        if (accept) begin
            if (target == LANE1) push1 = 1'b1;
            else                 push0 = 1'b1;
        end
    end

    assign bus.validOut0 = !empty0;
    assign bus.validOut1 = !empty1;
    assign pop0          = bus.validOut0 && bus.readyIn0;
    assign pop1          = bus.validOut1 && bus.readyIn1;

    // Selector mode parks the pointer on lane 0 so the next stripe run starts there.
    always_ff @(posedge clk) begin
        if (reset)              lanePtr <= LANE0;
        else if (!bus.stripeEn) lanePtr <= LANE0;
        else if (accept)        lanePtr <= otherLane(lanePtr);
    end

    lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane0 (
        .clk      (clk),
        .reset    (reset),
        .push     (push0),
        .pushData (bus.dataIn),
        .pop      (pop0),
        .headData (bus.dataOut0),
        .full     (full0),
        .empty    (empty0)
    );

    lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane1 (
        .clk      (clk),
        .reset    (reset),
        .push     (push1),
        .pushData (bus.dataIn),
        .pop      (pop1),
        .headData (bus.dataOut1),
        .full     (full1),
        .empty    (empty1)
    );

endmodule

// File: tb/tb_demux_stripe_l2.sv
// Directed bench for demux_stripe_l2: striping, selector, full lane, push+pop wrap, reset.
module tb_demux_stripe_l2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    demux_stripe_l2_if #(.DATA_W(8)) bus ();

    demux_stripe_l2 #(.DATA_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] nextByte;
    logic       accepted;

    initial begin
        reset        = 1'b1;
        bus.dataIn   = '0;
        bus.validIn  = 1'b0;
        bus.selector = 1'b0;
        bus.stripeEn = 1'b1;
        bus.readyIn0 = 1'b1;
        bus.readyIn1 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid0", bus.validOut0, 0);
        check("rst_valid1", bus.validOut1, 0);
        check("rst_ready", bus.readyOut, 1);
        check("rst_laneNext", bus.laneNext, 0);

        // Stripe 0x01..0x06: odd bytes on lane 0, even on lane 1, each one cycle after accept.
        for (int i = 1; i <= 6; i++) begin
            bus.dataIn  = 8'(i);
            bus.validIn = 1'b1;
            #1;
            check("stripe_laneNext", bus.laneNext, (i - 1) % 2);
            check("stripe_ready", bus.readyOut, 1);
            tick();
            if ((i % 2) == 1) begin
                check("stripe_v0", bus.validOut0, 1);
                check("stripe_d0", bus.dataOut0, i);
                check("stripe_v1_idle", bus.validOut1, 0);
            end else begin
                check("stripe_v1", bus.validOut1, 1);
                check("stripe_d1", bus.dataOut1, i);
                check("stripe_v0_idle", bus.validOut0, 0);
            end
        end
        bus.validIn = 1'b0;
        tick();
        check("stripe_drain_v0", bus.validOut0, 0);
        check("stripe_drain_v1", bus.validOut1, 0);

        // One more stripe byte leaves the pointer on lane 1.
        bus.dataIn  = 8'h07;
        bus.validIn = 1'b1;
        tick();
        bus.validIn = 1'b0;
        check("ptr_d0", bus.dataOut0, 8'h07);
        check("ptr_laneNext1", bus.laneNext, 1);
        tick();

        // Selector mode to lane 1.
        bus.stripeEn = 1'b0;
        bus.selector = 1'b1;
        #1;
        check("sel_laneNext", bus.laneNext, 1);
        bus.dataIn  = 8'hAA;
        bus.validIn = 1'b1;
        tick();
        check("sel_v1_aa", bus.validOut1, 1);
        check("sel_d1_aa", bus.dataOut1, 8'hAA);
        check("sel_v0_aa", bus.validOut0, 0);
        bus.dataIn = 8'hBB;
        tick();
        check("sel_v1_bb", bus.validOut1, 1);
        check("sel_d1_bb", bus.dataOut1, 8'hBB);
        check("sel_v0_bb", bus.validOut0, 0);
        bus.validIn = 1'b0;
        tick();
        check("sel_drain_v1", bus.validOut1, 0);
        check("sel_drain_v0", bus.validOut0, 0);
        bus.stripeEn = 1'b1;
        #1;
        check("ptr_forced0", bus.laneNext, 0);

        // Fill lane 0 with its consumer stalled.
        bus.stripeEn = 1'b0;
        bus.selector = 1'b0;
        bus.readyIn0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dataIn  = 8'(8'h10 + i);
            bus.validIn = 1'b1;
            #1;
            check("full_ready_pre", bus.readyOut, 1);
            tick();
        end
        check("full_ready_drop", bus.readyOut, 0);
        check("full_v0", bus.validOut0, 1);
        check("full_head", bus.dataOut0, 8'h10);
        bus.dataIn = 8'h14;
        tick();
        check("full_hold_v1", bus.validOut1, 0);
        check("full_hold_head", bus.dataOut0, 8'h10);
        check("full_hold_ready", bus.readyOut, 0);
        bus.selector = 1'b1;
        #1;
        check("full_retarget_ready", bus.readyOut, 1);
        check("full_retarget_lane", bus.laneNext, 1);
        tick();
        check("full_5th_v1", bus.validOut1, 1);
        check("full_5th_d1", bus.dataOut1, 8'h14);
        bus.validIn  = 1'b0;
        bus.selector = 1'b0;
        #1;
        check("full_lane0_blocked", bus.readyOut, 0);
        tick();
        check("full_lane1_drained", bus.validOut1, 0);

        // Release lane 0 while pushing every cycle; pointers wrap several times.
        q = '{8'h10, 8'h11, 8'h12, 8'h13};
        nextByte = 8'h20;
        bus.readyIn0 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.dataIn  = nextByte;
            bus.validIn = 1'b1;
            #1;
            accepted = (q.size() < 4);
            check("sim_ready", bus.readyOut, accepted);
            check("sim_head", bus.dataOut0, q[0]);
            void'(q.pop_front());
            if (accepted) begin
                q.push_back(nextByte);
                nextByte = nextByte + 8'h01;
            end
            tick();
        end
        bus.validIn = 1'b0;
        while (q.size() > 0) begin
            check("sim_drain_v0", bus.validOut0, 1);
            check("sim_drain_d0", bus.dataOut0, q.pop_front());
            tick();
        end
        check("sim_empty", bus.validOut0, 0);

        // Reset with bytes buffered on both lanes.
        bus.stripeEn = 1'b1;
        bus.readyIn0 = 1'b0;
        bus.readyIn1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dataIn  = 8'(8'h31 + i);
            bus.validIn = 1'b1;
            tick();
        end
        bus.validIn = 1'b0;
        check("mid_v0", bus.validOut0, 1);
        check("mid_v1", bus.validOut1, 1);
        check("mid_laneNext", bus.laneNext, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_v0", bus.validOut0, 0);
        check("mid_rst_v1", bus.validOut1, 0);
        check("mid_rst_ready", bus.readyOut, 1);
        check("mid_rst_laneNext", bus.laneNext, 0);
        bus.dataIn  = 8'h55;
        bus.validIn = 1'b1;
        tick();
        bus.validIn = 1'b0;
        check("mid_after_v0", bus.validOut0, 1);
        check("mid_after_d0", bus.dataOut0, 8'h55);
        check("mid_after_v1", bus.validOut1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
